// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// UNROLL bits per cycle, valid/ready handshake on both sides.
module muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int unsigned ITERS = XLEN / UNROLL;
  localparam int unsigned CW    = $clog2(ITERS + 1);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_d;

  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN:0]   hi, hi_n, sum;
  logic [XLEN-1:0] lo, lo_n, opb;

  logic            a_sgn, b_sgn, neg_d, div_zero, div_ovf, bypass, accept;
  logic [XLEN-1:0] a_mag, b_mag, bypass_res;

  // Request decode: operand magnitudes, result sign and the two divide shortcuts
  always_comb begin
    a_sgn      = rs1[XLEN-1] && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    b_sgn      = rs2[XLEN-1] && (op == 3'd1 || op == 3'd4 || op == 3'd6);
    a_mag      = a_sgn ? -rs1 : rs1;
    b_mag      = b_sgn ? -rs2 : rs2;
    neg_d      = (op[2] && op[1]) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero   = op[2] && (rs2 == '0);
    div_ovf    = (op == 3'd4 || op == 3'd6) && (rs2 == '1) &&
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}});
    bypass     = div_zero || div_ovf;
    bypass_res = '0;
    if (div_zero) bypass_res = op[1] ? rs1 : '1;
    else          bypass_res = op[1] ? '0 : rs1;
  end

  assign accept = (state == IDLE) && in_valid && !flush;

  // One CALC cycle: UNROLL steps of shift-add (lo = multiplier) or shift-subtract (lo = dividend)
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    sum  = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        hi_n = {hi_n[XLEN-1:0], lo_n[XLEN-1]};
        lo_n = {lo_n[XLEN-2:0], 1'b0};
        if (hi_n >= {1'b0, opb}) begin
          hi_n    = hi_n - {1'b0, opb};
          lo_n[0] = 1'b1;
        end
      end else begin
        sum          = lo_n[0] ? (hi_n + {1'b0, opb}) : hi_n;
        {hi_n, lo_n} = {1'b0, sum, lo_n[XLEN-1:1]};
      end
    end
  end

  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] div_mag, result_calc;

  // Final selection with sign correction, taken from the last iteration's values
  always_comb begin
    prod    = {hi_n[XLEN-1:0], lo_n};
    prod_s  = neg_q ? -prod : prod;
    div_mag = op_q[1] ? hi_n[XLEN-1:0] : lo_n;
    case (op_q)
      3'd0:             result_calc = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result_calc = prod_s[PW-1:XLEN];
      default:          result_calc = neg_q ? -div_mag : div_mag;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = bypass ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opb       <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        op_q  <= op;
        neg_q <= neg_d;
        hi    <= '0;
        lo    <= a_mag;
        opb   <= b_mag;
        cnt   <= bypass ? '0 : CW'(ITERS);
        if (bypass) result <= bypass_res;
      end else if (state == CALC) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) result <= result_calc;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors on UNROLL 1/2/4 instances,
// checking result values and out_valid latency.
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk, rst, in_valid, flush, out_ready;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [2:0]  iv, ir, ov;
  logic [31:0] res [3];
  logic [1:0]  sel;
  logic        mon_valid, mon_ir;
  logic [31:0] mon_res;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit seen = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sbq [$];

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]));
  muldiv_unit #(.XLEN(32), .UNROLL(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]));
  muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]));

  // Only the selected instance sees requests; the monitor watches that one
  assign iv = in_valid ? 3'(3'b001 << sel) : 3'b000;
  always_comb begin
    case (sel)
      2'd1:    begin mon_valid = ov[1]; mon_ir = ir[1]; mon_res = res[1]; end
      2'd2:    begin mon_valid = ov[2]; mon_ir = ir[2]; mon_res = res[2]; end
      default: begin mon_valid = ov[0]; mon_ir = ir[0]; mon_res = res[0]; end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: first valid cycle checks latency, handshake cycle checks result and pops
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mon_valid) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious out_valid: got result %h, required no output", mon_res);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk({sbq[0].name, " latency"}, 32'(cyc), 32'(sbq[0].cyc));
          end
          if (out_ready) begin
            chk(sbq[0].name, mon_res, sbq[0].res);
            void'(sbq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; drives one request and returns after its accept edge
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input int lat, input bit push);
    int g = 0;
    while (!mon_ir && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!mon_ir) begin
      vectors++;
      miscompares++;
      $display("FAIL %s accept timeout: in_ready got 0, required 1", name);
      return;
    end
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    if (push) sbq.push_back('{name, e, cyc + lat});
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; rs1 = ~a; rs2 = b ^ 32'h5a5a_0001;
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while (sbq.size() != 0 && g < budget) begin
      @(posedge clk); #1;
      g++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain timeout: %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic arith_set(input int l);
    issue("MULHU ffffffff^2", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, l, 1);
    issue("MUL ffffffff^2",   MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, l, 1);
    issue("DIV -7/2",         DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, l, 1);
    issue("REM -7/2",         REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, l, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; rs1 = '0; rs2 = '0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(mon_valid), 32'd0);
    chk("reset result", mon_res, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after reset", 32'(mon_ir), 32'd1);

    // Main arithmetic on UNROLL=1
    arith_set(33);
    issue("MULH 80000000^2",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1);
    issue("MULH -2*3",        MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33, 1);
    issue("MULHSU -1*ffffffff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1);
    issue("MUL 7*-3",         MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1);
    issue("DIVU 100/7",       DIVU,   32'd100,       32'd7,         32'd14,        33, 1);
    issue("REMU 100/7",       REMU,   32'd100,       32'd7,         32'd2,         33, 1);
    issue("DIV 7/-2",         DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1);
    issue("REM 7/-2",         REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33, 1);
    issue("DIVU 80000000/ffffffff", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,     33, 1);
    issue("REMU ffffffff/10", REMU,   32'hFFFF_FFFF, 32'h10,        32'hF,         33, 1);

    // Divide-by-zero and signed overflow shortcuts
    issue("DIVU x/0",         DIVU,   32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1, 1);
    issue("REMU x/0",         REMU,   32'h1234_5678, 32'd0,         32'h1234_5678, 1, 1);
    issue("DIV -5/0",         DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, 1);
    issue("REM -5/0",         REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 1);
    issue("DIV ovf",          DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue("REM ovf",          REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1);
    drain(100);

    // Backpressure: result and in_ready held while out_ready is low
    out_ready = 1'b0;
    issue("DIVU hold", DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
    begin
      int g = 0;
      while (!mon_valid && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid", 32'(mon_valid), 32'd1);
      chk("hold result", mon_res, 32'd14);
      chk("hold in_ready", 32'(mon_ir), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 32'(mon_valid), 32'd0);
    chk("release in_ready", 32'(mon_ir), 32'd1);
    drain(10);

    // Flush in CALC cycle 5 alongside a competing request
    issue("flush victim", MUL, 32'd3, 32'd5, 32'd0, 0, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; op = MUL; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush in_ready", 32'(mon_ir), 32'd1);
    chk("flush out_valid", 32'(mon_valid), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("post-flush in_ready", 32'(mon_ir), 32'd1);
    issue("MUL 3*5", MUL, 32'd3, 32'd5, 32'd15, 33, 1);
    drain(100);

    // Asynchronous reset in the middle of CALC
    issue("rst victim", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(mon_valid), 32'd0);
    chk("async rst result", mon_res, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst in_ready", 32'(mon_ir), 32'd1);
    repeat (40) @(posedge clk);
    #1;

    // Wider iteration steps
    sel = 2'd1;
    @(posedge clk); #1;
    arith_set(17);
    drain(100);
    sel = 2'd2;
    @(posedge clk); #1;
    arith_set(9);
    issue("U4 DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14, 9, 1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter UNROLL, default 1, giving the operand bits processed per iteration cycle; legal values are 1, 2 and 4, and UNROLL SHALL divide XLEN.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Reset, asynchronous and active-high.
REQ-005 in_valid  input  1  Request valid.
REQ-006 in_ready  output  1  Unit can accept a request.
REQ-007 op  input  3  Operation, RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 rs1  input  XLEN  Operand A (dividend or multiplicand).
REQ-009 rs2  input  XLEN  Operand B (divisor or multiplier).
REQ-010 flush  input  1  Abort any in-flight operation.
REQ-011 out_valid  output  1  Result valid.
REQ-012 out_ready  input  1  Consumer accepts the result.
REQ-013 result  output  XLEN  Operation result.

Function
REQ-014 The state machine SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 A request SHALL be accepted on the edge where in_valid=1 and in_ready=1; op and operands are captured on that edge, and later input changes have no effect.
REQ-017 On accept, signed operands (MULH, DIV, REM: both; MULHSU: rs1 only) SHALL be converted to magnitudes, and the result sign SHALL be recorded.
REQ-018 Normal accept SHALL move IDLE->CALC with iteration counter N = XLEN/UNROLL.
REQ-019 Each CALC cycle SHALL process UNROLL bits and decrement the counter; after N CALC cycles the state SHALL move to DONE.
REQ-020 On the CALC->DONE edge, result SHALL be registered with the sign correction applied.
REQ-021 Normal latency SHALL be fixed: accept at edge T gives out_valid=1 from edge T+N+1 (default 33 cycles).
REQ-022 Multiply SHALL form the 2*XLEN-bit product; MUL returns the low XLEN bits, and MULH, MULHSU and MULHU return the high XLEN bits.
REQ-023 Divide SHALL use restoring shift-subtract; DIV and DIVU return the quotient, and REM and REMU return the remainder.
REQ-024 Remainder sign SHALL follow the dividend, and the quotient SHALL be truncated toward zero.
REQ-025 Divide by zero (rs2=0, ops 4-7) SHALL bypass CALC (IDLE->DONE, out_valid at T+1) with quotient = all ones and remainder = rs1.
REQ-026 Signed overflow (DIV or REM with rs1 = most negative value and rs2 = -1) SHALL bypass CALC with quotient = rs1 and remainder = 0, out_valid at T+1.
REQ-027 In DONE, result and out_valid SHALL hold stable until out_ready=1; on that edge the state SHALL move to IDLE.
REQ-028 No new request SHALL be accepted on the DONE->IDLE edge; the minimum request spacing is N+2 cycles.
REQ-029 flush=1 SHALL force the state to IDLE on the next edge from any state; it discards any pending result without asserting out_valid.
REQ-030 flush SHALL take priority over both accept and out_ready on the same edge, so in_valid is ignored that cycle.
REQ-031 All arithmetic SHALL be exact modulo 2^XLEN, with no saturation and no exceptions raised.

Reset
REQ-032 rst=1 SHALL immediately and asynchronously force IDLE, counter=0, result=0 and out_valid=0, with in_ready=1 after release.
REQ-033 Reset mid-operation SHALL abandon the operation, and no stale result SHALL appear after release.
REQ-034 Release of rst SHALL be synchronous to clk by the integrating system; the block adds no synchronizer.

Verification
REQ-035 MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result 0xFFFFFFFE, out_valid exactly 33 cycles after accept; MUL of the same operands -> 0x00000001.
REQ-036 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 DIVU rs1=0x12345678, rs2=0 -> 0xFFFFFFFF at T+1; REMU with the same operands -> 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM of that -> 0.
REQ-038 Hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-039 flush at CALC cycle 5 together with in_valid=1 -> IDLE next edge, no out_valid, request not accepted; a subsequent MUL 3*5 -> 15.
REQ-040 Assert rst asynchronously mid-CALC -> out_valid=0 and result=0 immediately; rerun of REQ-035 at UNROLL=2 and UNROLL=4 -> same values with latency 17 and 9 cycles respectively.
